jt12_dac_feed: RTL

- Upstream feeder for the PCM up-rate stage: decodes YM2612 part-I DAC register writes (0x2A data, 0x2B enable, 0x2C bit 3 low-resolution LSB).
- Buffers DAC samples in a small FIFO.
- Releases one 9-bit signed sample per rising edge of the `zero` sample tick, as `pcm` plus a one-cycle `pcm_wr` strobe, so CPU write jitter never reaches the interpolator.

---
 rtl/jt12_dac_feed.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/jt12_dac_feed.sv
// jt12_dac_feed: decodes the YM2612 part-I DAC registers (0x2A data,
// 0x2B enable, 0x2C low-resolution LSB), queues DAC samples in a small
// FIFO and releases one 9-bit signed sample per rising edge of `zero`.
//
// Handshake: there is no backpressure. A 0x2A write is a push that is
// accepted when enabled and not full (or when a pop frees a slot the same
// cycle). The `zero` rising edge is a pop request. pcm_wr is a one-cycle
// valid strobe that qualifies the new pcm value.
module jt12_dac_feed #(
    parameter int AW = 2
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          clk_en,
    input  logic          zero,
    input  logic          a1,
    input  logic          addr_wr,
    input  logic          data_wr,
    input  logic [7:0]    din,
    output logic          dac_en,
    output logic [8:0]    pcm,
    output logic          pcm_wr,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underrun
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

    logic [7:0]    addr_q;
    logic          part_q;
    logic          zero_q;
    logic          lsb;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    mem [DEPTH];

    logic          data_ok;
    logic          wr_2a;
    logic          wr_2b;
    logic          wr_2c;
    logic          tick;
    logic          dac_off;
    logic          pop;
    logic          starve;
    logic          push_req;
    logic          push;
    logic          drop;
    logic [8:0]    head;
    logic [AW:0]   level_nxt;

    // Register decode, tick detection and push/pop arbitration
    always_comb begin
        data_ok   = clk_en & data_wr & ~addr_wr & ~part_q;
        wr_2a     = data_ok & (addr_q == 8'h2A);
        wr_2b     = data_ok & (addr_q == 8'h2B);
        wr_2c     = data_ok & (addr_q == 8'h2C);
        tick      = zero & ~zero_q;
        // Disabling flushes everything and takes priority over a tick.
        dac_off   = wr_2b & ~din[7];
        // Pop only sees entries already stored; a same-cycle push is not visible.
        pop       = tick & dac_en & (level != '0) & ~dac_off;
        starve    = tick & dac_en & (level == '0) & ~dac_off;
        push_req  = wr_2a & dac_en;
        // A simultaneous pop frees a slot, so a full FIFO can still accept.
        push      = push_req & ((level != FULL) | pop);
        drop      = push_req & (level == FULL) & ~pop;
        head      = mem[rd_ptr];
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Tick edge register and CPU address/part latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            addr_q <= 8'h00;
            part_q <= 1'b0;
        end else begin
            zero_q <= zero;
            if (clk_en && addr_wr) begin
                addr_q <= din;
                part_q <= a1;
            end
        end
    end

    // DAC enable and low-resolution LSB registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_en <= 1'b0;
            lsb    <= 1'b0;
        end else begin
            if (wr_2b) dac_en <= din[7];
            if (wr_2c) lsb    <= din[3];
        end
    end

    // FIFO pointers and occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (dac_off) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
        end
    end

    // FIFO storage: entry is {byte, lsb}
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {din, lsb};
    end

    // Output sample: flip the byte MSB to turn offset-binary into signed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcm    <= 9'd0;
            pcm_wr <= 1'b0;
        end else begin
            pcm_wr <= pop;
            if (dac_off)  pcm <= 9'd0;
            else if (pop) pcm <= {~head[8], head[7:0]};
        end
    end

    // Sticky error flags; a same-cycle set overrides the 0x2B clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wr_2b) begin
                overflow <= 1'b0;
                underrun <= 1'b0;
            end
            if (drop)   overflow <= 1'b1;
            if (starve) underrun <= 1'b1;
        end
    end

endmodule
